// File: rtl/axi_stream_hdr_pkg.sv
// Shared types and helpers for the AXI-Stream header inserter.
// Holds the FSM state encoding and the MSB-aligned byte-enable mask builder.
package axi_stream_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int unsigned MAX_BYTES = 64;

    // Sets the top `count` of the low `width` bits; callers truncate to their keep width.
    function automatic logic [MAX_BYTES-1:0] mask(input int unsigned count, input int unsigned width);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if ((i < width) && ((i + count) >= width)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-entry AXI-Stream output register with a load enable.
// Holds its contents while valid_out && !ready_out; clears when drained.
module axis_pipe_reg #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [DATA_WD-1:0]      data_i,
    input  logic [DATA_BYTE_WD-1:0] keep_i,
    input  logic                    last_i,
    input  logic                    ready_out,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out
);

    logic                    valid_q, valid_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic                    last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
            last_d  = last_i;
        end else if (ready_out) begin
            valid_d = 1'b0;
            data_d  = '0;
            keep_d  = '0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign last_out  = last_q;

endmodule

// File: rtl/axi_stream_insert_header_pkt.sv
// Prepends an n-byte header to each AXI-Stream packet, realigning payload bytes
// through a residual register; an overflow byte group is emitted as a FLUSH beat.
module axi_stream_insert_header_pkt
    import axi_stream_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert
);

    state_t                  state_q, state_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [BYTE_CNT_WD-1:0]  n_q, n_d;
    logic [BYTE_CNT_WD-1:0]  fcnt_q, fcnt_d;

    logic                    can_load;
    logic                    load;
    logic [DATA_WD-1:0]      beat;
    logic [DATA_WD-1:0]      beat_masked;
    logic [DATA_BYTE_WD-1:0] keep_n;
    logic                    last_n;
    logic [BYTE_CNT_WD-1:0]  hdr_cnt;
    logic [2*DATA_WD-1:0]    data_shift;
    logic [2*DATA_WD-1:0]    flush_shift;
    int unsigned             m_i;
    int unsigned             tot_i;

    assign can_load     = !valid_out || ready_out;
    assign ready_in     = (state_q == DATA) && can_load;
    assign ready_insert = (state_q == IDLE) && !rst;
    assign hdr_cnt      = (32'(byte_insert_cnt) > DATA_BYTE_WD) ? BYTE_CNT_WD'(DATA_BYTE_WD)
                                                                 : byte_insert_cnt;

    // Shifting {residual, next} right by n bytes yields residual low n bytes on the MSB side.
    assign data_shift  = {res_q, data_in} >> {n_q, 3'b000};
    assign flush_shift = {res_q, {DATA_WD{1'b0}}} >> {n_q, 3'b000};

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        n_d     = n_q;
        fcnt_d  = fcnt_q;
        load    = 1'b0;
        beat    = '0;
        keep_n  = '0;
        last_n  = 1'b0;
        m_i     = 32'($countones(keep_in));
        tot_i   = m_i + 32'(n_q);
        case (state_q)
            IDLE: begin
                if (valid_insert && ready_insert) begin
                    res_d   = data_insert;
                    n_d     = hdr_cnt;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (valid_in && ready_in) begin
                    load  = 1'b1;
                    beat  = data_shift[DATA_WD-1:0];
                    res_d = data_in;
                    if (!last_in) begin
                        keep_n = '1;
                    end else if (tot_i <= DATA_BYTE_WD) begin
                        keep_n  = DATA_BYTE_WD'(mask(tot_i, DATA_BYTE_WD));
                        last_n  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        keep_n  = '1;
                        fcnt_d  = BYTE_CNT_WD'(tot_i - DATA_BYTE_WD);
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (can_load) begin
                    load    = 1'b1;
                    beat    = flush_shift[DATA_WD-1:0];
                    keep_n  = DATA_BYTE_WD'(mask(32'(fcnt_q), DATA_BYTE_WD));
                    last_n  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_masked = '0;
        for (int unsigned b = 0; b < DATA_BYTE_WD; b++) begin
            if (keep_n[b]) begin
                beat_masked[8*b +: 8] = beat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            n_q     <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            n_q     <= n_d;
            fcnt_q  <= fcnt_d;
        end
    end

    axis_pipe_reg #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data_i    (beat_masked),
        .keep_i    (keep_n),
        .last_i    (last_n),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .keep_out  (keep_out),
        .last_out  (last_out)
    );

endmodule

// File: tb/tb_axi_stream_insert_header_pkt.sv
// Scoreboard bench for the header inserter: expected beats come from a byte-stream
// model (header bytes then payload bytes, rechunked into words) queued at packet start.
module tb_axi_stream_insert_header_pkt;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out = 1'b1;
    logic        valid_insert = 1'b0;
    logic [31:0] data_insert = '0;
    logic [2:0]  byte_insert_cnt = '0;
    logic        ready_insert;

    int    n_checks = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    logic  rdy_pat[$];
    logic [31:0] pd [8];
    logic  prev_fire = 1'b0;

    axi_stream_insert_header_pkt #(
        .DATA_WD (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .ready_in        (ready_in),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .ready_out       (ready_out),
        .valid_insert    (valid_insert),
        .data_insert     (data_insert),
        .byte_insert_cnt (byte_insert_cnt),
        .ready_insert    (ready_insert)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Downstream ready: follows a queued pattern when one is loaded, otherwise high.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_pat.size() > 0) ready_out = rdy_pat.pop_front();
            else ready_out = 1'b1;
        end
    end

    // Output monitor: the head of the scoreboard must sit on the bus whenever valid_out is high.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_fire = 1'b0;
            end else begin
                if (prev_fire) check("latency", valid_out, 1'b1);
                if (valid_out) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid", valid_out, 1'b0);
                    end else begin
                        check("data", data_out, exp_q[0].d);
                        check("keep", keep_out, exp_q[0].k);
                        check("last", last_out, exp_q[0].l);
                        if (ready_out) void'(exp_q.pop_front());
                    end
                end
                prev_fire = valid_in && ready_in;
            end
        end
    end

    task automatic build_expected(input int n, input logic [31:0] hdr, input int nb, input logic [3:0] lk);
        logic [7:0] bytes[$];
        int    nn;
        beat_t bt;
        nn = (n > 4) ? 4 : n;
        for (int i = nn - 1; i >= 0; i--) bytes.push_back(hdr[8*i +: 8]);
        for (int b = 0; b < nb; b++)
            for (int j = 3; j >= 0; j--)
                if ((b < nb - 1) || lk[j]) bytes.push_back(pd[b][8*j +: 8]);
        while (bytes.size() > 0) begin
            bt = '0;
            for (int j = 3; j >= 0; j--) begin
                if (bytes.size() > 0) begin
                    bt.d[8*j +: 8] = bytes.pop_front();
                    bt.k[j] = 1'b1;
                end
            end
            bt.l = (bytes.size() == 0);
            exp_q.push_back(bt);
        end
    endtask

    task automatic drive_beat(input int b, input int nb, input logic [3:0] lk);
        valid_in = 1'b1;
        data_in  = pd[b];
        keep_in  = (b == nb - 1) ? lk : 4'hF;
        last_in  = (b == nb - 1);
    endtask

    // Caller is positioned just after a rising edge.
    task automatic send_pkt(input int n, input logic [31:0] hdr, input int nb,
                            input logic [3:0] lk, input bit early);
        int t;
        build_expected(n, hdr, nb, lk);
        valid_insert    = 1'b1;
        data_insert     = hdr;
        byte_insert_cnt = 3'(n);
        if (early) drive_beat(0, nb, lk);
        t = 0;
        @(negedge clk);
        while (!ready_insert && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("hdr_timeout", ready_insert, 1'b1);
        if (early) check("idle_ready_in", ready_in, 1'b0);
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
        for (int b = 0; b < nb; b++) begin
            drive_beat(b, nb, lk);
            t = 0;
            @(negedge clk);
            while (!ready_in && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check("beat_timeout", ready_in, 1'b1);
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        data_in  = '0;
        keep_in  = '0;
        last_in  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_out"}, valid_out, 1'b0);
        check({tag, "_data_out"}, data_out, 32'h0);
        check({tag, "_keep_out"}, keep_out, 4'h0);
        check({tag, "_last_out"}, last_out, 1'b0);
        check({tag, "_ready_in"}, ready_in, 1'b0);
        check({tag, "_ready_insert"}, ready_insert, 1'b0);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-byte header, full last beat spills into a flush beat.
        pd[0] = 32'h11223344; pd[1] = 32'h55667788;
        send_pkt(2, 32'h0000AABB, 2, 4'hF, 1'b0);
        wait_drain();

        // Three-byte header plus one payload byte fills exactly one beat.
        pd[0] = 32'h11223344;
        send_pkt(3, 32'h00CCDDEE, 1, 4'h8, 1'b0);
        wait_drain();

        // Passthrough, with the first beat offered before the header is taken.
        pd[0] = 32'h01020304; pd[1] = 32'h02A0B0C0; pd[2] = 32'h03AABBCC;
        send_pkt(0, 32'h12345678, 3, 4'hE, 1'b1);
        wait_drain();
        @(negedge clk);
        check("ready_insert_back", ready_insert, 1'b1);
        @(posedge clk);
        #1;

        // Downstream stalls during the first scenario.
        pd[0] = 32'h11223344; pd[1] = 32'h55667788;
        fork
            send_pkt(2, 32'h0000AABB, 2, 4'hF, 1'b0);
            begin
                repeat (2) @(negedge clk);
                rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            end
        join
        wait_drain();

        // Back-to-back packets: n=1, then a full-width header.
        pd[0] = 32'hA1A2A3A4; pd[1] = 32'hB1B2B3B4;
        send_pkt(1, 32'h000000C5, 2, 4'hC, 1'b0);
        pd[0] = 32'h10203040; pd[1] = 32'h50607080;
        send_pkt(4, 32'hDEADBEEF, 2, 4'h8, 1'b0);
        wait_drain();

        // Oversized count is clamped to a full header, with random downstream stalls.
        for (int i = 0; i < 24; i++) rdy_pat.push_back(1'($urandom_range(0, 1)));
        pd[0] = 32'h0F1E2D3C; pd[1] = 32'h4B5A6978; pd[2] = 32'h8796A5B4;
        send_pkt(7, 32'hCAFEF00D, 3, 4'hE, 1'b0);
        wait_drain();

        // Reset while the second beat of the first scenario is on the bus.
        pd[0] = 32'h11223344; pd[1] = 32'h55667788;
        build_expected(2, 32'h0000AABB, 2, 4'hF);
        valid_insert = 1'b1; data_insert = 32'h0000AABB; byte_insert_cnt = 3'd2;
        @(negedge clk);
        @(posedge clk); #1;
        valid_insert = 1'b0;
        drive_beat(0, 2, 4'hF);
        @(negedge clk);
        @(posedge clk); #1;
        drive_beat(1, 2, 4'hF);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midpkt_rst");
        exp_q.delete();
        valid_in = 1'b0; last_in = 1'b0; keep_in = '0; data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        pd[0] = 32'h11223344;
        send_pkt(3, 32'h00CCDDEE, 1, 4'h8, 1'b0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d beats outstanding", exp_q.size());
        $fatal(1);
    end

endmodule
